alu_sliced: RTL and testbench

Parametrised successor to the 8-bit add/subtract ALU. It computes WIDTH-bit results one SLICE-bit slice per clock, LSB first, with the carry registered between slices. This models chained 4-bit adder chips at any width. Adds carry-in ops, logic ops, a start/busy/done handshake, and a registered flag set (C, Z, N, V). Sits between the A/B registers and the data bus, and drives dbus only when assertBarE is low.

---
 rtl/alu_sliced.sv | 170 +++++++++++++++++
 tb/tb_alu_sliced.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sliced.sv
`default_nettype none
// ============================================================================
// Module      : alu_sliced
// Description : WIDTH-bit ALU evaluated one SLICE-bit slice per clock, LSB
//               first, with a registered inter-slice carry and C/Z/N/V flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sliced #(
   parameter int WIDTH = 8,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] areg,
   input  logic [WIDTH-1:0] breg,
   input  logic             assertBarE,
   output logic [WIDTH-1:0] dbus,
   output logic             aIsZero,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flagCarry,
   output logic             flagZero,
   output logic             flagNeg,
   output logic             flagOverflow
);

   localparam int c_nslice = (SLICE > 0) ? (WIDTH / SLICE) : 1;
   localparam int c_idx_w  = (c_nslice > 1) ? $clog2(c_nslice) : 1;
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nslice - 1);

   localparam logic [2:0] c_op_add   = 3'd0;
   localparam logic [2:0] c_op_sub   = 3'd1;
   localparam logic [2:0] c_op_adc   = 3'd2;
   localparam logic [2:0] c_op_sbc   = 3'd3;
   localparam logic [2:0] c_op_and   = 3'd4;
   localparam logic [2:0] c_op_or    = 3'd5;
   localparam logic [2:0] c_op_xor   = 3'd6;
   localparam logic [2:0] c_op_passb = 3'd7;

   generate
      if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
         $fatal(1, "alu_sliced: WIDTH must be a non-zero multiple of SLICE");
      end
   endgenerate

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;          // holds b' (already inverted for SUB/SBC)
   logic [2:0]         r_op;
   logic               r_cin;
   logic [c_idx_w-1:0] r_idx;
   logic [WIDTH-1:0]   r_shadow;

   logic [SLICE-1:0]   w_a_sl;
   logic [SLICE-1:0]   w_b_sl;
   logic [SLICE:0]     w_sum;
   logic [SLICE-1:0]   w_slice;
   logic [WIDTH-1:0]   w_full;
   logic               w_ovf;
   logic               w_binv;
   logic               w_cin0;

   assign aIsZero = (areg == '0);
   assign dbus    = assertBarE ? {WIDTH{1'bz}} : result;

   // Carry-in and B inversion chosen from the live request at the start edge.
   always_comb begin
      w_binv = (op == c_op_sub) || (op == c_op_sbc);
      w_cin0 = 1'b0;
      case (op)
         c_op_sub:           w_cin0 = 1'b1;
         c_op_adc, c_op_sbc: w_cin0 = flagCarry;
         default:            w_cin0 = 1'b0;
      endcase
   end

   always_comb begin
      w_a_sl  = r_a[r_idx*SLICE +: SLICE];
      w_b_sl  = r_b[r_idx*SLICE +: SLICE];
      w_sum   = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_cin};
      w_slice = w_sum[SLICE-1:0];
      case (r_op)
         c_op_and:   w_slice = w_a_sl & w_b_sl;
         c_op_or:    w_slice = w_a_sl | w_b_sl;
         c_op_xor:   w_slice = w_a_sl ^ w_b_sl;
         c_op_passb: w_slice = w_b_sl;
         default:    w_slice = w_sum[SLICE-1:0];
      endcase
      w_full = r_shadow;
      w_full[r_idx*SLICE +: SLICE] = w_slice;
      w_ovf  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_full[WIDTH-1] != r_a[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_RUN;
         S_RUN:   if (r_idx == c_last_idx) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= c_op_add;
         r_cin        <= 1'b0;
         r_idx        <= '0;
         r_shadow     <= '0;
         result       <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         flagCarry    <= 1'b0;
         flagZero     <= 1'b0;
         flagNeg      <= 1'b0;
         flagOverflow <= 1'b0;
      end else begin
         done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (start) begin
               r_a   <= areg;
               r_b   <= w_binv ? ~breg : breg;
               r_op  <= op;
               r_cin <= w_cin0;
               r_idx <= '0;
               busy  <= 1'b1;
            end
         end else begin
            r_shadow <= w_full;
            r_cin    <= w_sum[SLICE];
            r_idx    <= r_idx + 1'b1;
            if (r_idx == c_last_idx) begin
               // Only the completed value ever reaches result and the flags.
               r_idx    <= '0;
               result   <= w_full;
               busy     <= 1'b0;
               done     <= 1'b1;
               flagZero <= (w_full == '0);
               flagNeg  <= w_full[WIDTH-1];
               if (!r_op[2]) begin
                  flagCarry    <= w_sum[SLICE];
                  flagOverflow <= w_ovf;
               end else begin
                  flagOverflow <= 1'b0;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_sliced.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sliced
// Description : Self-checking bench for alu_sliced (8/4 and 16/4 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sliced;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start8, start16;
   logic [2:0]  op8, op16;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;
   logic        oe8_n, oe16_n;
   logic [7:0]  dbus8;
   logic [15:0] dbus16;
   logic        z8, z16, busy8, busy16, done8, done16;
   logic [7:0]  res8;
   logic [15:0] res16;
   logic        c8, zf8, n8, v8, c16, zf16, n16, v16;

   int checks = 0;
   int errors = 0;
   bit mc8  = 1'b0;
   bit mc16 = 1'b0;

   alu_sliced #(.WIDTH(8), .SLICE(4)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .areg(a8), .breg(b8),
      .assertBarE(oe8_n), .dbus(dbus8), .aIsZero(z8), .busy(busy8), .done(done8),
      .result(res8), .flagCarry(c8), .flagZero(zf8), .flagNeg(n8), .flagOverflow(v8)
   );

   alu_sliced #(.WIDTH(16), .SLICE(4)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .op(op16), .areg(a16), .breg(b16),
      .assertBarE(oe16_n), .dbus(dbus16), .aIsZero(z16), .busy(busy16), .done(done16),
      .result(res16), .flagCarry(c16), .flagZero(zf16), .flagNeg(n16), .flagOverflow(v16)
   );

   // Whole-word reference: arithmetic on full integers, no slicing.
   function automatic void ref_model(input int w, input logic [2:0] o, input longint a,
                                     input longint b, input bit cf, output longint r,
                                     output bit c, output bit v);
      longint mask;
      longint bp;
      longint full;
      longint ci;
      mask = (longint'(1) << w) - 1;
      c = cf;
      v = 1'b0;
      if (o < 3'd4) begin
         bp   = (o == 3'd1 || o == 3'd3) ? (~b & mask) : b;
         ci   = (o == 3'd0) ? 0 : (o == 3'd1) ? 1 : longint'(cf);
         full = a + bp + ci;
         r    = full & mask;
         c    = ((full >> w) & 1) != 0;
         v    = (((a >> (w-1)) & 1) == ((bp >> (w-1)) & 1)) &&
                (((r >> (w-1)) & 1) != ((a >> (w-1)) & 1));
      end else begin
         case (o)
            3'd4:    r = a & b;
            3'd5:    r = a | b;
            3'd6:    r = a ^ b;
            default: r = b;
         endcase
      end
   endfunction

   // Issues one op at a negedge, returns at the negedge where done is seen.
   task automatic do_op(input bit wide, input logic [2:0] o, input logic [15:0] av,
                        input logic [15:0] bv, input bit hammer, output int lat,
                        output int bcnt, output logic [15:0] res, output logic [3:0] fl);
      bit seen;
      if (wide) begin op16 = o; a16 = av; b16 = bv; start16 = 1'b1; end
      else begin op8 = o; a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1; end
      lat = 0; bcnt = 0; seen = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom);
         a16 = 16'($urandom); b16 = 16'($urandom);
         if (hammer) begin op8 = 3'($urandom_range(7, 0)); op16 = 3'($urandom_range(7, 0)); end
         else begin start8 = 1'b0; start16 = 1'b0; end
         if (wide ? busy16 : busy8) bcnt++;
         seen = wide ? done16 : done8;
      end
      start8 = 1'b0; start16 = 1'b0;
      res = wide ? res16 : {8'h00, res8};
      fl  = wide ? {c16, zf16, n16, v16} : {c8, zf8, n8, v8};
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (res8 !== 8'h00) begin errors++; $display("FAIL reset_res8: got %h want 00", res8); end
      checks++; if ({c8, zf8, n8, v8} !== 4'b0000) begin errors++; $display("FAIL reset_flags8: got %b want 0000", {c8, zf8, n8, v8}); end
      checks++; if ({busy8, done8} !== 2'b00) begin errors++; $display("FAIL reset_busy_done8: got %b want 00", {busy8, done8}); end
      checks++; if ({res16, busy16, done16} !== 18'h0) begin errors++; $display("FAIL reset_dut16: got %h want 0", {res16, busy16, done16}); end
   endtask

   task automatic test_add();
      int lat, bc; logic [15:0] r; logic [3:0] f;
      do_op(1'b0, 3'd0, 16'h3C, 16'hC4, 1'b0, lat, bc, r, f);
      checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency: got %0d want 3", lat); end
      checks++; if (bc !== 2) begin errors++; $display("FAIL add_busy_cycles: got %0d want 2", bc); end
      checks++; if (r !== 16'h00) begin errors++; $display("FAIL add_result: got %h want 00", r); end
      checks++; if (f !== 4'b1100) begin errors++; $display("FAIL add_flags: got %b want 1100", f); end
      @(negedge clk);
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", done8); end
      oe8_n = 1'b0; a8 = 8'h00; #1;
      checks++; if ({dbus8, z8} !== {8'h00, 1'b1}) begin errors++; $display("FAIL dbus8_azero: got %h want 001", {dbus8, z8}); end
      oe8_n = 1'b1;
      mc8 = 1'b1;
   endtask

   task automatic test_sub();
      int lat, bc; logic [15:0] r; logic [3:0] f;
      do_op(1'b0, 3'd1, 16'h10, 16'h20, 1'b0, lat, bc, r, f);
      checks++; if ({r, f} !== {16'hF0, 4'b0010}) begin errors++; $display("FAIL sub_neg: got %h/%b want f0/0010", r, f); end
      do_op(1'b0, 3'd1, 16'h20, 16'h10, 1'b0, lat, bc, r, f);
      checks++; if ({r, f} !== {16'h10, 4'b1000}) begin errors++; $display("FAIL sub_pos: got %h/%b want 10/1000", r, f); end
      mc8 = 1'b1;
   endtask

   task automatic test_overflow_logic();
      int lat, bc; logic [15:0] r; logic [3:0] f;
      do_op(1'b0, 3'd0, 16'h7F, 16'h01, 1'b0, lat, bc, r, f);
      checks++; if ({r, f} !== {16'h80, 4'b0011}) begin errors++; $display("FAIL add_ovf: got %h/%b want 80/0011", r, f); end
      do_op(1'b0, 3'd4, 16'hF0, 16'h3C, 1'b0, lat, bc, r, f);
      checks++; if ({r, f} !== {16'h30, 4'b0000}) begin errors++; $display("FAIL and_flags: got %h/%b want 30/0000", r, f); end
      mc8 = 1'b0;
   endtask

   task automatic test_back_to_back();
      int lat, bc; logic [15:0] r; logic [3:0] f;
      do_op(1'b0, 3'd0, 16'hFF, 16'h01, 1'b0, lat, bc, r, f);
      checks++; if ({r, f} !== {16'h00, 4'b1100}) begin errors++; $display("FAIL chain_add: got %h/%b want 00/1100", r, f); end
      do_op(1'b0, 3'd2, 16'h00, 16'h00, 1'b0, lat, bc, r, f);
      checks++; if ({r, f} !== {16'h01, 4'b0000}) begin errors++; $display("FAIL chain_adc: got %h/%b want 01/0000", r, f); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL chain_latency: got %0d want 3", lat); end
      do_op(1'b0, 3'd1, 16'h00, 16'h01, 1'b0, lat, bc, r, f);
      checks++; if ({r, f} !== {16'hFF, 4'b0010}) begin errors++; $display("FAIL chain_sub: got %h/%b want ff/0010", r, f); end
      do_op(1'b0, 3'd3, 16'h05, 16'h01, 1'b0, lat, bc, r, f);
      checks++; if ({r, f} !== {16'h03, 4'b1000}) begin errors++; $display("FAIL chain_sbc: got %h/%b want 03/1000", r, f); end
      mc8 = 1'b1;
   endtask

   task automatic test_busy_ignore();
      int lat, bc; logic [15:0] r; logic [3:0] f;
      do_op(1'b0, 3'd0, 16'h12, 16'h34, 1'b1, lat, bc, r, f);
      checks++; if (lat !== 3) begin errors++; $display("FAIL ignore_latency: got %0d want 3", lat); end
      checks++; if ({r, f} !== {16'h46, 4'b0000}) begin errors++; $display("FAIL ignore_result: got %h/%b want 46/0000", r, f); end
      mc8 = 1'b0;
   endtask

   task automatic test_reset_midop();
      int lat, bc; logic [15:0] r; logic [3:0] f; bit seen;
      do_op(1'b0, 3'd0, 16'h7F, 16'h01, 1'b0, lat, bc, r, f);
      checks++; if ({r, f} !== {16'h80, 4'b0011}) begin errors++; $display("FAIL pre_reset_op: got %h/%b want 80/0011", r, f); end
      op8 = 3'd0; a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0; reset = 1'b1;
      checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b want 1", busy8); end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks++; if ({res8, c8, zf8, n8, v8, busy8, done8} !== 14'h0) begin
         errors++; $display("FAIL midop_reset_state: got %h want 0", {res8, c8, zf8, n8, v8, busy8, done8});
      end
      seen = 1'b0;
      repeat (4) begin @(negedge clk); if (done8) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midop_no_done: got %b want 0", seen); end
      mc8 = 1'b0;
   endtask

   task automatic test_wide();
      int lat, bc; logic [15:0] r; logic [3:0] f;
      do_op(1'b1, 3'd0, 16'h0FFF, 16'h0001, 1'b0, lat, bc, r, f);
      checks++; if (lat !== 5) begin errors++; $display("FAIL wide_latency: got %0d want 5", lat); end
      checks++; if (bc !== 4) begin errors++; $display("FAIL wide_busy_cycles: got %0d want 4", bc); end
      checks++; if ({r, f} !== {16'h1000, 4'b0000}) begin errors++; $display("FAIL wide_result: got %h/%b want 1000/0000", r, f); end
      oe16_n = 1'b1; #1;
      checks++; if (dbus16 === 16'h1000) begin errors++; $display("FAIL wide_dbus_off: got %h want not driven", dbus16); end
      oe16_n = 1'b0; #1;
      checks++; if (dbus16 !== 16'h1000) begin errors++; $display("FAIL wide_dbus_on: got %h want 1000", dbus16); end
      oe16_n = 1'b1;
      a16 = 16'h0000; #1;
      checks++; if (z16 !== 1'b1) begin errors++; $display("FAIL wide_azero1: got %b want 1", z16); end
      a16 = 16'h0100; #1;
      checks++; if (z16 !== 1'b0) begin errors++; $display("FAIL wide_azero0: got %b want 0", z16); end
      mc16 = 1'b0;
   endtask

   task automatic test_random();
      int lat, bc, w; logic [15:0] r, av, bv; logic [3:0] f, ef; logic [2:0] o;
      bit wide, ec, ev; longint er;
      for (int i = 0; i < 40; i++) begin
         wide = bit'($urandom_range(1, 0));
         o    = 3'($urandom_range(7, 0));
         w    = wide ? 16 : 8;
         av   = wide ? 16'($urandom) : {8'h00, 8'($urandom)};
         bv   = wide ? 16'($urandom) : {8'h00, 8'($urandom)};
         ref_model(w, o, longint'(av), longint'(bv), wide ? mc16 : mc8, er, ec, ev);
         ef = {ec, er == 0, ((er >> (w-1)) & 1) != 0, ev};
         do_op(wide, o, av, bv, 1'b0, lat, bc, r, f);
         checks++; if (lat !== (wide ? 5 : 3)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, wide ? 5 : 3); end
         checks++; if (r !== 16'(er)) begin errors++; $display("FAIL rand_result[%0d] op%0d %h,%h: got %h want %h", i, o, av, bv, r, 16'(er)); end
         checks++; if (f !== ef) begin errors++; $display("FAIL rand_flags[%0d] op%0d %h,%h: got %b want %b", i, o, av, bv, f, ef); end
         if (wide) mc16 = ec; else mc8 = ec;
      end
   endtask

   initial begin
      reset = 1'b1; start8 = 1'b0; start16 = 1'b0; op8 = 3'd0; op16 = 3'd0;
      a8 = 8'h00; b8 = 8'h00; a16 = 16'h0000; b16 = 16'h0000; oe8_n = 1'b1; oe16_n = 1'b1;
      test_reset();
      test_add();
      test_sub();
      test_overflow_logic();
      test_back_to_back();
      test_busy_ignore();
      test_reset_midop();
      test_wide();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
